// File: rtl/rsc_block_encoder_if.sv
// Handshake and control bundle for one RSC constituent encoder.
// The slave modport is the encoder side, the master modport is the
// block that feeds it and drains its symbols.
interface rsc_block_encoder_if #(
  parameter int LEN_W = 13
);
  logic             start;
  logic [LEN_W-1:0] blk_len;
  logic             punct;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_sys;
  logic             out_par;
  logic             out_par_en;
  logic             out_tail;
  logic             busy;
  logic             done;

  modport slave (
    input  start, blk_len, punct, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sys, out_par, out_par_en, out_tail,
           busy, done
  );

  modport master (
    output start, blk_len, punct, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sys, out_par, out_par_en, out_tail,
           busy, done
  );
endinterface

// File: rtl/rsc_block_encoder.sv
// Recursive systematic convolutional constituent encoder.
// Encodes one block of blk_len bits, then drives MEM tail steps that
// return the shift register to zero. A single output slot with a
// valid/ready handshake carries systematic, parity and tail flags;
// odd data parities can be punctured for rate matching.
module rsc_block_encoder #(
  parameter int             MEM     = 3,
  parameter logic [MEM:0]   FB_POLY = 4'b1101,
  parameter logic [MEM:0]   FF_POLY = 4'b1011,
  parameter int             LEN_W   = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rsc_block_encoder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    FLUSH
  } state_t;

  state_t           state;
  logic [MEM-1:0]   s;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_q;
  logic             punct_q;
  logic [2:0]       tail_cnt;

  logic             out_valid_q;
  logic             out_sys_q;
  logic             out_par_q;
  logic             out_par_en_q;
  logic             out_tail_q;
  logic             done_q;

  logic             slot_free;
  logic             fb;
  logic             ff_state;
  logic             u;
  logic             a;
  logic             p;
  logic             punct_now;
  logic [MEM-1:0]   s_next;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign punct_now = punct_q && idx[0];
  assign s_next    = {s[MEM-2:0], a};

  // Trellis step: feedback/parity taps from the current state; in TAIL the
  // input is chosen equal to the feedback sum so the new bit a is zero.
  always_comb begin
    fb       = 1'b0;
    ff_state = 1'b0;
    for (int k = 1; k <= MEM; k++) begin
      fb       = fb ^ (FB_POLY[k] & s[k-1]);
      ff_state = ff_state ^ (FF_POLY[k] & s[k-1]);
    end
    u = (state == TAIL) ? fb : bus.in_bit;
    a = u ^ fb;
    p = (FF_POLY[0] & a) ^ ff_state;
  end

  // Block sequencer: accepts data into the output slot, then tail steps,
  // then waits for the last symbol to drain before pulsing done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      idx          <= '0;
      len_q        <= '0;
      punct_q      <= 1'b0;
      tail_cnt     <= '0;
      out_valid_q  <= 1'b0;
      out_sys_q    <= 1'b0;
      out_par_q    <= 1'b0;
      out_par_en_q <= 1'b0;
      out_tail_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.start && (bus.blk_len != '0)) begin
            len_q    <= bus.blk_len;
            punct_q  <= bus.punct;
            s        <= '0;
            idx      <= '0;
            tail_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (bus.in_valid && slot_free) begin
            out_valid_q  <= 1'b1;
            out_sys_q    <= u;
            out_par_q    <= p & !punct_now;
            out_par_en_q <= !punct_now;
            out_tail_q   <= 1'b0;
            s            <= s_next;
            if (idx == len_q - LEN_W'(1)) begin
              idx      <= '0;
              tail_cnt <= '0;
              state    <= TAIL;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        TAIL: begin
          if (slot_free) begin
            out_valid_q  <= 1'b1;
            out_sys_q    <= u;
            out_par_q    <= p;
            out_par_en_q <= 1'b1;
            out_tail_q   <= 1'b1;
            s            <= s_next;
            if (tail_cnt == 3'(MEM - 1)) begin
              state <= FLUSH;
            end else begin
              tail_cnt <= tail_cnt + 3'd1;
            end
          end
        end
        FLUSH: begin
          if (out_valid_q && bus.out_ready) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == DATA) && slot_free;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sys    = out_sys_q;
  assign bus.out_par    = out_par_q;
  assign bus.out_par_en = out_par_en_q;
  assign bus.out_tail   = out_tail_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

  // Termination must have returned the trellis to the all-zero state.
  a_tail_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (state == FLUSH) |-> (s == '0));

endmodule

// File: tb/tb_rsc_block_encoder.sv
// Scoreboard bench for rsc_block_encoder: the stimulus side pushes the
// expected symbol for each accepted bit and tail step, a monitor pops and
// compares every consumed symbol and watches stability under stall.
module tb_rsc_block_encoder;

  typedef struct packed {
    logic sys;
    logic par;
    logic par_en;
    logic tail;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rsc_block_encoder_if #(.LEN_W(13)) bus ();

  rsc_block_encoder #(
    .MEM(3), .FB_POLY(4'b1101), .FF_POLY(4'b1011), .LEN_W(13)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  sym_t sb[$];

  // reference model state: default LTE polynomials written out by hand
  logic [2:0]  ms;
  logic [12:0] m_idx;
  logic        m_punct;

  // out_ready pattern source
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         rdy_ph   = 0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic pm);
    ms      = 3'b000;
    m_idx   = '0;
    m_punct = pm;
  endtask

  // g0 = 1+D^2+D^3 gives fb = s1^s2; g1 = 1+D+D^3 gives p = a^s0^s2
  task automatic model_sym(input logic b, input logic tl, output sym_t r);
    logic fbm, um, am, pm, en;
    fbm = ms[1] ^ ms[2];
    um  = tl ? fbm : b;
    am  = um ^ fbm;
    pm  = am ^ ms[0] ^ ms[2];
    en  = tl || !(m_punct && m_idx[0]);
    r   = '{sys: um, par: pm & en, par_en: en, tail: tl};
    ms  = {ms[1:0], am};
    if (!tl) m_idx = m_idx + 13'd1;
  endtask

  // out_ready driver: held high or cycling the stall pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        bus.out_ready = rdy_pat[rdy_ph % 4];
        rdy_ph++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // monitor: compare consumed symbols, check hold during stalls, count done
  initial begin
    sym_t cur, held, e;
    logic hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        cur = '{sys: bus.out_sys, par: bus.out_par, par_en: bus.out_par_en,
                tail: bus.out_tail};
        if (hold) begin
          check_output("stall_hold", {bus.out_valid, cur}, {1'b1, held});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check_output("unexpected_symbol", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_output("symbol", 32'(cur), 32'(e));
          end
          hold = 1'b0;
        end else if (bus.out_valid) begin
          held = cur;
          hold = 1'b1;
        end else begin
          hold = 1'b0;
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  // begins at posedge+2, ends at posedge+2
  task automatic start_block(input logic [12:0] len, input logic pm);
    bus.start   = 1'b1;
    bus.blk_len = len;
    bus.punct   = pm;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    model_reset(pm);
  endtask

  // offer one bit until accepted; expected symbol pushed before acceptance
  task automatic apply_stimulus(input logic b, input sym_t exp);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        ok = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b0;
    if (!ok) check_output("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget, input int done_before);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk);
      #2;
      if (done_cnt != done_before) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2;
    check_output("done_count", 32'(done_cnt), 32'(done_before + 1));
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    check_output("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_model_block(input int len, input bit rnd);
    sym_t e;
    logic b;
    for (int i = 0; i < len; i++) begin
      b = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      model_sym(b, 1'b0, e);
      apply_stimulus(b, e);
    end
    for (int t = 0; t < 3; t++) begin
      model_sym(1'b0, 1'b1, e);
      sb.push_back(e);
    end
  endtask

  sym_t hand_data[4]   = '{'{1,1,1,0}, '{0,1,1,0}, '{0,1,1,0}, '{0,1,1,0}};
  sym_t hand_punct[4]  = '{'{1,1,1,0}, '{0,0,0,0}, '{0,1,1,0}, '{0,0,0,0}};
  sym_t hand_tail[3]   = '{'{1,1,1,1}, '{0,1,1,1}, '{1,1,1,1}};
  logic hand_bits[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
  sym_t zero_data      = '{0,0,1,0};
  sym_t zero_tail      = '{0,0,1,1};

  task automatic run_hand_block(input bit pm);
    int d0;
    d0 = done_cnt;
    start_block(13'd4, pm);
    check_output("busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(hand_bits[i], pm ? hand_punct[i] : hand_data[i]);
    end
    for (int t = 0; t < 3; t++) sb.push_back(hand_tail[t]);
    wait_done(50, d0);
  endtask

  initial begin
    int d0;
    bus.start    = 1'b0;
    bus.blk_len  = '0;
    bus.punct    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    model_reset(1'b0);

    // reset state
    #13;
    check_output("reset_outputs",
                 {bus.out_valid, bus.in_ready, bus.busy, bus.done, bus.out_sys,
                  bus.out_par, bus.out_par_en, bus.out_tail}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // directed block 1,0,0,0 unpunctured, then punctured
    $display("[TB] directed block, punct=0");
    run_hand_block(1'b0);
    $display("[TB] directed block, punct=1");
    run_hand_block(1'b1);

    // all-zero block with a stray start mid-block
    $display("[TB] all-zero block with mid-block start");
    d0 = done_cnt;
    start_block(13'd8, 1'b0);
    fork
      begin
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, zero_data);
        for (int t = 0; t < 3; t++) sb.push_back(zero_tail);
      end
      begin
        repeat (4) @(posedge clk);
        #3;
        bus.start   = 1'b1;
        bus.blk_len = 13'd3;
        @(posedge clk);
        #3;
        bus.start = 1'b0;
      end
    join
    wait_done(50, d0);

    // zero-length start is ignored
    $display("[TB] zero-length start");
    d0 = done_cnt;
    bus.start   = 1'b1;
    bus.blk_len = 13'd0;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output("busy_zero_len", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #2;
    end
    check_output("done_zero_len", 32'(done_cnt), 32'(d0));

    // random data under 1,0,0,1 back-pressure
    $display("[TB] random block of 100 with stalls");
    rdy_mode = 1'b1;
    d0 = done_cnt;
    start_block(13'd100, 1'b0);
    run_model_block(100, 1'b1);
    wait_done(600, d0);
    rdy_mode = 1'b0;
    @(posedge clk);
    #2;

    // punctured random block with stalls
    $display("[TB] random punctured block of 9 with stalls");
    rdy_mode = 1'b1;
    d0 = done_cnt;
    start_block(13'd9, 1'b1);
    run_model_block(9, 1'b1);
    wait_done(100, d0);
    rdy_mode = 1'b0;
    @(posedge clk);
    #2;

    // reset in the middle of a block
    $display("[TB] reset at data index 2");
    d0 = done_cnt;
    start_block(13'd10, 1'b0);
    begin
      sym_t e;
      for (int i = 0; i < 2; i++) begin
        model_sym(1'b1, 1'b0, e);
        apply_stimulus(1'b1, e);
      end
    end
    rst_n = 1'b0;
    #1;
    check_output("midreset_outputs",
                 {bus.out_valid, bus.in_ready, bus.busy, bus.done, bus.out_sys,
                  bus.out_par, bus.out_par_en, bus.out_tail}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_output("midreset_no_done", 32'(done_cnt), 32'(d0));
    run_hand_block(1'b0);

    // maximum block length, index counter must not wrap
    $display("[TB] maximum-length block");
    d0 = done_cnt;
    start_block(13'h1FFF, 1'b0);
    run_model_block(8191, 1'b1);
    wait_done(100, d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rsc_block_encoder.md
Name: rsc_block_encoder

Overview:
- Parametrised, single-clock recursive systematic convolutional (RSC) constituent encoder for the turbo encoder datapath.
- Encodes one block of blk_len bits, then appends MEM trellis-termination tail steps that return the state to zero.
- Optional rate-matching puncture of parity bits.
- Replaces the divided slow-clock scheme with valid/ready handshakes on a single clock; two instances plus an interleaver form the next turbo encoder.

Parameters:
- MEM, 3: encoder memory (constraint length − 1); legal range 2..6.
- FB_POLY, 4'b1101: feedback polynomial, MEM+1 bits; bit k is the D^k coefficient; bit 0 must be 1. Default is LTE g0 = 1+D^2+D^3.
- FF_POLY, 4'b1011: feed-forward polynomial, same bit convention. Default is LTE g1 = 1+D+D^3.
- LEN_W, 13: width of the block-length field (maximum block 2^LEN_W − 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a block, honoured only in IDLE.
- blk_len  in  LEN_W  block length; sampled on an accepted start.
- punct  in  1  puncture mode; sampled on an accepted start.
- in_valid  in  1  data bit valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_bit  in  1  data bit.
- out_valid  out  1  output slot holds a symbol.
- out_ready  in  1  downstream consumes the slot.
- out_sys  out  1  systematic bit (data or tail).
- out_par  out  1  parity bit.
- out_par_en  out  1  1 = parity transmitted; 0 = punctured, and out_par is driven 0.
- out_tail  out  1  symbol is a tail step.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last tail symbol is consumed.

Behaviour:
- Reset (asserted low): state IDLE, shift state s = 0, counters = 0. out_valid, in_ready, busy, done, out_sys, out_par, out_par_en and out_tail all read 0. Reset mid-block aborts the block without a done pulse.
- Encoder state: s[MEM-1:0]; s[k-1] holds the feedback bit a delayed by k steps.
- Feedback bit: a = u ^ XOR over k=1..MEM of (FB_POLY[k] & s[k-1]).
- Parity: p = (FF_POLY[0] & a) ^ XOR over k=1..MEM of (FF_POLY[k] & s[k-1]).
- State update per step: s <= {s[MEM-2:0], a}.
- FSM IDLE:
  - start with blk_len ≠ 0: latch blk_len and punct, clear s and the index counter, go to DATA.
  - start with blk_len = 0: ignored; stay IDLE, no done pulse.
- FSM DATA:
  - in_ready = out slot free, where free means (!out_valid | out_ready).
  - On in_valid & in_ready: u = in_bit; load the slot with sys = u, par = p, tail = 0; advance s; increment the index.
  - After index blk_len−1 is accepted, go to TAIL.
- FSM TAIL:
  - in_ready = 0.
  - For MEM steps, each taken when the slot is free: u = XOR over k=1..MEM of (FB_POLY[k] & s[k-1]), which forces a = 0. Load sys = u, par = p, tail = 1.
  - After the last step, go to FLUSH.
- FSM FLUSH: wait until the final slot is consumed (out_valid & out_ready); pulse done for one cycle; go to IDLE.
- Latency: an accepted bit appears on the outputs the next cycle.
- Throughput: one symbol per cycle when out_ready is held high.
- Back-pressure: out_valid stays asserted and all output fields hold stable until out_ready is seen.
- Puncture: with punct = 1, data symbols with an odd index get out_par_en = 0 and out_par = 0. Tail symbols are never punctured. With punct = 0, out_par_en = 1 always.
- start while busy is ignored. in_valid outside DATA is ignored.
- s is zero after the final tail step; this is checked by an assertion.
- The index counter does not wrap: blk_len = 2^LEN_W − 1 must complete correctly.

Test Plan:
- Defaults, blk_len = 4, bits 1,0,0,0, out_ready = 1, punct = 0 → data symbols sys/par = 1/1, 0/1, 0/1, 0/1; tail sys 1,0,1 with par 1,1,1; done pulses once; final s = 000.
- blk_len = 8, all-zero input → all 11 symbols have sys = 0 and par = 0; out_tail = 1 on the last 3 symbols only.
- punct = 1, blk_len = 4, bits 1,0,0,0 → out_par_en pattern 1,0,1,0 on data and 1,1,1 on tail; punctured symbols have out_par = 0.
- out_ready toggled 1,0,0,1 repeatedly with random data, blk_len = 100 → no symbol is lost or duplicated; output fields stay stable while stalled; the stream matches the reference model.
- start with blk_len = 0 → busy stays 0 and done never asserts. A second start pulsed mid-block → ignored; the block completes normally.
- reset driven low at data index 2 of a 10-bit block → all outputs go to 0 immediately with no done pulse; a following start with blk_len = 4 encodes cleanly from s = 0.
